display_serializer: RTL and testbench

Parametrised N-digit 7-segment frame serializer for chained external shift-register LED drivers. It snapshots packed BCD/hex digits and decimal points on a start strobe, decodes them to segment bytes with optional leading-zero blanking, and shifts the frame out on a divided serial clock. A latch pulse and a one-cycle completion strobe end each frame. It sits between the clock/time-keeping core and the display pins, and replaces the fixed 6-digit output path.

---
 rtl/display_serializer_if.sv | 26 ++
 rtl/display_serializer.sv | 126 ++++++++++++
 tb/tb_display_serializer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/display_serializer_if.sv
// Host/pin-side bundle for the 7-segment frame serializer: frame request,
// status strobes and the three serial lines to the chained shift registers.
interface display_serializer_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      i_en;
    logic                      i_lzb;
    logic                      i_start_stb;
    logic [4*NUM_DIGITS-1:0]   i_digits;
    logic [NUM_DIGITS-1:0]     i_dp;
    logic                      o_busy;
    logic                      o_done_stb;
    logic                      o_serial_data;
    logic                      o_serial_clk;
    logic                      o_serial_latch;

    modport master (
        output i_en, i_lzb, i_start_stb, i_digits, i_dp,
        input  o_busy, o_done_stb, o_serial_data, o_serial_clk, o_serial_latch
    );

    modport slave (
        input  i_en, i_lzb, i_start_stb, i_digits, i_dp,
        output o_busy, o_done_stb, o_serial_data, o_serial_clk, o_serial_latch
    );
endinterface

// File: rtl/display_serializer.sv
// N-digit 7-segment frame serializer: snapshots digits on start, decodes to
// segment bytes (optional leading-zero blanking) and shifts them out with a latch.
module display_serializer #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 25,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    display_serializer_if.slave  bus
);
    localparam int W  = 8 * NUM_DIGITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(W);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   phase_q;
    logic [BW-1:0]   bit_q;
    logic [W-1:0]    shreg_q;
    logic [W-1:0]    frame_d;
    logic            busy_q, done_q, data_q, sclk_q, latch_q;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    // Decoded frame, built from live inputs and only consumed on an accepted start.
    always_comb begin
        logic       seen;
        logic       blank;
        logic [3:0] dig;
        frame_d = '0;
        seen    = 1'b0;
        blank   = 1'b0;
        dig     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            dig   = bus.i_digits[4*k +: 4];
            blank = bus.i_lzb && !seen && (dig == 4'h0) && (k != 0);
            if (dig != 4'h0) seen = 1'b1;
            frame_d[8*k +: 8] = bus.i_en ? {bus.i_dp[k], blank ? 7'h00 : seg7(dig)} : 8'h00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    // A start in the DONE cycle is accepted just like in IDLE.
                    if (bus.i_start_stb) begin
                        state_q <= SHIFT_LO;
                        phase_q <= '0;
                        bit_q   <= '0;
                        shreg_q <= frame_d;
                        data_q  <= MSB_FIRST ? frame_d[W-1] : frame_d[0];
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT_LO: begin
                    if (phase_q == PW'(CLK_DIV - 1)) begin
                        state_q <= SHIFT_HI;
                        phase_q <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_q == PW'(CLK_DIV - 1)) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b0;
                        if (bit_q == BW'(W - 1)) begin
                            state_q <= LATCH;
                            latch_q <= 1'b1;
                            data_q  <= 1'b0;
                        end else begin
                            state_q <= SHIFT_LO;
                            bit_q   <= bit_q + 1'b1;
                            shreg_q <= MSB_FIRST ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};
                            data_q  <= MSB_FIRST ? shreg_q[W-2] : shreg_q[1];
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_q == PW'(CLK_DIV - 1)) begin
                        state_q <= DONE;
                        phase_q <= '0;
                        latch_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy         = busy_q;
    assign bus.o_done_stb     = done_q;
    assign bus.o_serial_data  = data_q;
    assign bus.o_serial_clk   = sclk_q;
    assign bus.o_serial_latch = latch_q;
endmodule

// File: tb/tb_display_serializer.sv
// Scoreboard bench: expected frame bits queued at start, popped on each
// rising serial clock; frame timing measured from the accepting edge.
module tb_display_serializer;
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    bit sb  [$];
    bit sb1 [$];

    always #5 clk = ~clk;

    display_serializer_if #(.NUM_DIGITS(6)) if0 ();
    display_serializer_if #(.NUM_DIGITS(1)) if1 ();

    display_serializer u_dut0 (.i_clk(clk), .i_reset(rst), .bus(if0));
    display_serializer #(.NUM_DIGITS(1), .CLK_DIV(1), .MSB_FIRST(1'b0))
        u_dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));

    function automatic logic [47:0] model(logic [23:0] d, logic [5:0] dp, bit en, bit lzb, int nd);
        logic [47:0] f = '0;
        logic [6:0]  s;
        int top = -1;
        for (int k = nd - 1; k >= 0; k--)
            if (top < 0 && d[4*k +: 4] != 4'h0) top = k;
        for (int k = 0; k < nd; k++) begin
            s = SEG[d[4*k +: 4]];
            if (lzb && k > top && k != 0) s = 7'h00;
            f[8*k +: 8] = en ? {dp[k], s} : 8'h00;
        end
        return f;
    endfunction

    task automatic launch(logic [23:0] d, logic [5:0] dp, bit en, bit lzb, logic [47:0] exp);
        if0.i_digits = d; if0.i_dp = dp; if0.i_en = en; if0.i_lzb = lzb;
        if0.i_start_stb = 1'b1;
        for (int i = 47; i >= 0; i--) sb.push_back(exp[i]);
    endtask

    // Caller is at a negedge with start already driven by launch().
    task automatic run_frame(string name, bit disturb, bit chain,
                             logic [23:0] nd, logic [5:0] ndp, bit nen, bit nlzb, logic [47:0] nexp);
        int n = 0, n_done = 0, busy_cnt = 0, latch_cnt = 0, first_latch = 0;
        int rises = 0, first_rise = 0, bad_latch = 0;
        bit prev = 1'b0, got;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if0.i_start_stb = 1'b0;
                checks++;
                if (if0.o_busy !== 1'b1) begin
                    errors++; $display("FAIL %s busy_at_t0+1: got %b exp 1", name, if0.o_busy);
                end
            end
            if (disturb && n == 5) begin if0.i_start_stb = 1'b1; if0.i_digits = 24'($urandom); end
            if (disturb && n == 6) if0.i_start_stb = 1'b0;
            if (disturb && n == 700) begin if0.i_digits = 24'($urandom); if0.i_dp = 6'($urandom); end
            if (if0.o_busy) busy_cnt++;
            if (if0.o_serial_latch) begin
                latch_cnt++;
                if (first_latch == 0) first_latch = n;
                if (if0.o_serial_clk || if0.o_serial_data) bad_latch++;
            end
            if (if0.o_serial_clk && !prev) begin
                rises++;
                if (first_rise == 0) first_rise = n;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL %s extra_bit: got rise %0d exp none", name, rises);
                end else begin
                    got = sb.pop_front();
                    if (if0.o_serial_data !== got) begin
                        errors++;
                        $display("FAIL %s bit%0d: got %b exp %b", name, rises - 1, if0.o_serial_data, got);
                    end
                end
            end
            prev = if0.o_serial_clk;
            if (if0.o_done_stb) begin n_done = n; break; end
        end
        checks++;
        if (n_done != 2426) begin
            errors++; $display("FAIL %s done_time: got %0d exp 2426", name, n_done);
        end
        checks++;
        if (busy_cnt != 2425 || if0.o_busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_len: got %0d exp 2425", name, busy_cnt);
        end
        checks++;
        if (latch_cnt != 25 || first_latch != 2401 || bad_latch != 0) begin
            errors++;
            $display("FAIL %s latch: got len %0d start %0d bad %0d exp len 25 start 2401 bad 0",
                     name, latch_cnt, first_latch, bad_latch);
        end
        checks++;
        if (rises != 48 || first_rise != 26 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s sclk: got rises %0d first %0d left %0d exp 48 26 0",
                     name, rises, first_rise, sb.size());
        end
        sb.delete();
        if (chain) begin
            launch(nd, ndp, nen, nlzb, nexp);
        end else begin
            @(negedge clk);
            checks++;
            if ({if0.o_busy, if0.o_done_stb, if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch} !== 5'b0) begin
                errors++; $display("FAIL %s idle_outputs: got %b exp 00000", name,
                    {if0.o_busy, if0.o_done_stb, if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch});
            end
        end
    endtask

    task automatic test_reset();
        if0.i_start_stb = 0; if0.i_en = 0; if0.i_lzb = 0; if0.i_digits = '0; if0.i_dp = '0;
        if1.i_start_stb = 0; if1.i_en = 0; if1.i_lzb = 0; if1.i_digits = '0; if1.i_dp = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({if0.o_busy, if0.o_done_stb, if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch,
             if1.o_busy, if1.o_done_stb, if1.o_serial_data, if1.o_serial_clk, if1.o_serial_latch} !== 10'b0) begin
            errors++; $display("FAIL reset_outputs: got %b%b%b%b%b exp 00000", if0.o_busy, if0.o_done_stb,
                               if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch);
        end
    endtask

    task automatic test_digits();
        launch(24'h123456, 6'b0, 1, 0, 48'h065B4F666D7D);
        run_frame("digits_123456", 0, 0, '0, '0, 0, 0, '0);
        launch(24'hA9F0E8, 6'b101010, 1, 0, model(24'hA9F0E8, 6'b101010, 1, 0, 6));
        run_frame("digits_hex_dp", 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_lzb();
        launch(24'h000070, 6'b000001, 1, 1, 48'h0000000007BF);
        run_frame("lzb_on", 0, 0, '0, '0, 0, 0, '0);
        launch(24'h000070, 6'b000001, 1, 0, 48'h3F3F3F3F07BF);
        run_frame("lzb_off", 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_disable();
        launch(24'h987654, 6'b111111, 0, 1, 48'h0);
        run_frame("disabled", 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_ignore_start();
        launch(24'h0A1B2C, 6'b010001, 1, 1, model(24'h0A1B2C, 6'b010001, 1, 1, 6));
        run_frame("ignore_start", 1, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_back_to_back();
        launch(24'h000305, 6'b000100, 1, 1, model(24'h000305, 6'b000100, 1, 1, 6));
        run_frame("b2b_first", 0, 1, 24'h4D00C1, 6'b100000, 1, 0, model(24'h4D00C1, 6'b100000, 1, 0, 6));
        run_frame("b2b_second", 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_reset_mid();
        int rises = 0, bad = 0;
        bit prev = 1'b0;
        launch(24'h777777, 6'b0, 1, 0, model(24'h777777, 6'b0, 1, 0, 6));
        for (int n = 1; n <= 3000 && rises < 21; n++) begin
            @(negedge clk);
            if (n == 1) if0.i_start_stb = 1'b0;
            if (if0.o_serial_clk && !prev) rises++;
            prev = if0.o_serial_clk;
        end
        checks++;
        if (rises != 21) begin
            errors++; $display("FAIL reset_mid_reach_bit20: got %0d exp 21", rises);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({if0.o_busy, if0.o_done_stb, if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b exp 00000",
                {if0.o_busy, if0.o_done_stb, if0.o_serial_data, if0.o_serial_clk, if0.o_serial_latch});
        end
        rst = 1'b0;
        sb.delete();
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (if0.o_serial_latch || if0.o_done_stb || if0.o_busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_mid_no_latch: got %0d active cycles exp 0", bad);
        end
        launch(24'h654321, 6'b000010, 1, 1, model(24'h654321, 6'b000010, 1, 1, 6));
        run_frame("after_reset", 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic test_lsb_first();
        logic [3:0] dv  [3] = '{4'h8, 4'h4, 4'h0};
        bit         dpv [3] = '{1'b1, 1'b0, 1'b0};
        bit         lzv [3] = '{1'b0, 1'b0, 1'b1};
        for (int p = 0; p < 3; p++) begin
            int n = 0, n_done = 0, busy_cnt = 0, rises = 0;
            bit prev = 1'b0, got;
            logic [47:0] f;
            f = model({20'h0, dv[p]}, {5'b0, dpv[p]}, 1, lzv[p], 1);
            for (int i = 0; i < 8; i++) sb1.push_back(f[i]);
            if1.i_digits = dv[p]; if1.i_dp = dpv[p]; if1.i_en = 1'b1; if1.i_lzb = lzv[p];
            if1.i_start_stb = 1'b1;
            while (n < 40) begin
                @(negedge clk);
                n++;
                if (n == 1) if1.i_start_stb = 1'b0;
                if (if1.o_busy) busy_cnt++;
                if (if1.o_serial_clk && !prev) begin
                    rises++;
                    checks++;
                    got = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
                    if (if1.o_serial_data !== got) begin
                        errors++;
                        $display("FAIL lsb_p%0d_bit%0d: got %b exp %b", p, rises - 1, if1.o_serial_data, got);
                    end
                end
                prev = if1.o_serial_clk;
                if (if1.o_done_stb) begin n_done = n; break; end
            end
            checks++;
            if (n_done != 18 || busy_cnt != 17 || rises != 8 || sb1.size() != 0) begin
                errors++;
                $display("FAIL lsb_p%0d_timing: got done %0d busy %0d rises %0d exp 18 17 8", p, n_done, busy_cnt, rises);
            end
            sb1.delete();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lzb();
        test_disable();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_lsb_first();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
